time_set_ctrl: RTL

//  Timekeeping and time-setting controller for the digital clock. Holds BCD hh:mm:ss, advances it once per second

---
 rtl/clock_pkg.sv | 7 +
 rtl/bcd2_counter.sv | 23 ++
 rtl/time_set_ctrl.sv | 74 +++++++
 3 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared types and field limits for the clock time-setting logic.
package clock_pkg;
  typedef enum logic [1:0] {RUN = 2'b00, SET_HH = 2'b01, SET_MM = 2'b10, SET_SS = 2'b11} set_state_t;
  typedef logic [7:0] bcd2_t;
  localparam bcd2_t HH_MAX = 8'h23;
  localparam bcd2_t MS_MAX = 8'h59;
endpackage

// File: rtl/bcd2_counter.sv
// bcd2_counter: two-digit BCD counter with programmable wrap limit and synchronous clear.
module bcd2_counter
  import clock_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  inc,
  input  logic  clr,
  input  bcd2_t max,
  output bcd2_t value,
  output logic  wrap
);
  bcd2_t value_q, value_d;
  assign wrap = inc & (value_q == max);
  // Limit is checked on the whole pair before the units digit rolls over.
  always_comb value_d = clr ? '0 : !inc ? value_q : wrap ? '0 :
                        (value_q[3:0] == 4'd9) ? {value_q[7:4] + 4'd1, 4'd0} : value_q + 8'd1;
  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else value_q <= value_d;
  end
  assign value = value_q;
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: BCD hh:mm:ss timekeeping with button-driven set mode; SET_TIMEOUT_EN adds idle auto-exit.
module time_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV     = 4,
  parameter int TIMEOUT_SECS = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_mode,
  input  logic        btn_shift,
  input  logic        btn_add,
  output logic [23:0] time_date,
  output logic [1:0]  blink,
  output logic        set_active
);
  localparam int TW = $clog2(TICK_DIV);
  set_state_t    state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [2:0]    btn_q, pressed;
  logic          sec_tick, run, exit_set, tmo;
  logic          mode_p, shift_p, add_p;
  logic          ss_inc, mm_inc, hh_inc, ss_wrap, mm_wrap;
  bcd2_t         hh, mm, ss;
  assign pressed  = {btn_mode, btn_shift, btn_add} & ~btn_q;
  assign mode_p   = pressed[2];
  assign shift_p  = pressed[1] & ~pressed[2];
  assign add_p    = pressed[0] & ~|pressed[2:1];
  assign sec_tick = tick_q == TW'(TICK_DIV - 1);
  assign run      = state_q == RUN;
  assign exit_set = (mode_p & ~run) | tmo;
  // Leaving set mode realigns the divider so the first second is a whole one.
  assign tick_d   = (sec_tick | exit_set) ? '0 : tick_q + TW'(1);
  always_comb begin
    state_d = state_q;
    state_d = exit_set ? RUN : mode_p ? SET_HH :
              (shift_p & ~run) ? ((state_q == SET_SS) ? SET_HH : set_state_t'(state_q + 2'd1)) : state_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      tick_q  <= '0;
      btn_q   <= '0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      btn_q   <= {btn_mode, btn_shift, btn_add};
    end
  end
`ifdef SET_TIMEOUT_EN
  localparam int OW = $clog2(TIMEOUT_SECS + 1);
  logic [OW-1:0] to_q, to_d;
  logic          any_press;
  assign any_press = |pressed;
  assign tmo  = ~run & sec_tick & ~any_press & (to_q == OW'(TIMEOUT_SECS - 1));
  assign to_d = (run | any_press) ? '0 : sec_tick ? to_q + OW'(1) : to_q;
  always_ff @(posedge clk) begin
    if (rst) to_q <= '0;
    else to_q <= to_d;
  end
`else
  assign tmo = 1'b0;
`endif
  // Carries only ripple while running; set-mode adds never carry.
  assign ss_inc = (run & sec_tick) | (state_q == SET_SS & add_p);
  assign mm_inc = (run & ss_wrap)  | (state_q == SET_MM & add_p);
  assign hh_inc = (run & mm_wrap)  | (state_q == SET_HH & add_p);
  bcd2_counter u_ss (.clk(clk), .rst(rst), .inc(ss_inc), .clr(exit_set), .max(MS_MAX), .value(ss), .wrap(ss_wrap));
  bcd2_counter u_mm (.clk(clk), .rst(rst), .inc(mm_inc), .clr(1'b0), .max(MS_MAX), .value(mm), .wrap(mm_wrap));
  bcd2_counter u_hh (.clk(clk), .rst(rst), .inc(hh_inc), .clr(1'b0), .max(HH_MAX), .value(hh), .wrap());
  assign time_date  = {hh, mm, ss};
  assign blink      = state_q;
  assign set_active = ~run;
endmodule
